pipe_ctrl: RTL and testbench

- Central pipeline sequencing controller for the 6-stage in-order core (pc, if/id, id/ex, ex/mem, mem/wb, wb).
- Arbitrates stall requests from id, ex and mem into the shared stall[5:0] vector that every pipeline register, including mem/wb, consumes.
- Sequences exception/eret flushes and supplies the redirect PC.
- Runs a stall watchdog and a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_stall_watchdog.sv | 27 ++
 rtl/pipe_ctrl.sv | 69 ++++++
 tb/tb_pipe_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall vector codes, controller state encodings and shared constants
package pipe_ctrl_pkg;
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;
   localparam logic [1:0] CTRL_RUN     = 2'd0;
   localparam logic [1:0] CTRL_FLUSH   = 2'd1;
   localparam logic [1:0] CTRL_RECOVER = 2'd2;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
   localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000e;
   localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
   localparam logic        RST_ENABLE     = 1'b1;
endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: saturating consecutive-stall counter with a one-cycle timeout pulse
module stall_watchdog #(
   parameter int unsigned MAX_STALL = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic clear,
   output logic timeout
);
   localparam logic [7:0] LIMIT = 8'(MAX_STALL);
   logic [7:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= 8'd0;
         timeout <= 1'b0;
      end else if (clear) begin
         cnt     <= 8'd0;
         timeout <= 1'b0;
      end else if (active && cnt != LIMIT) begin
         cnt     <= cnt + 8'd1;
         timeout <= (cnt + 8'd1) == LIMIT;
      end else begin
         timeout <= 1'b0;
      end
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall arbitration, exception/eret flush sequencing, stall watchdog and stall counter
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter logic [31:0] ERET_CODE    = ERET_CODE_DEF,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MAX_STALL    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles
);
   logic [1:0] state;
   logic [2:0] fcnt;
   logic       exc_take;
   assign exc_take = state == CTRL_RUN && excepttype_i != ZERO_WORD;
   // an exception accepted this cycle drops any concurrent stall request
   always_comb
      stall = (rst == RST_ENABLE || state != CTRL_RUN || exc_take) ? STALL_NONE :
              stallreq_mem ? STALL_MEM :
              stallreq_ex  ? STALL_EX  :
              stallreq_id  ? STALL_ID  : STALL_NONE;
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state  <= CTRL_RUN;
         fcnt   <= 3'd0;
         flush  <= 1'b0;
         new_pc <= ZERO_WORD;
      end else begin
         case (state)
            CTRL_RUN: if (exc_take) begin
               state  <= CTRL_FLUSH;
               flush  <= 1'b1;
               new_pc <= excepttype_i == ERET_CODE ? cp0_epc_i : EXC_VECTOR;
               fcnt   <= 3'(FLUSH_CYCLES - 1);
            end
            CTRL_FLUSH: if (fcnt == 3'd0) begin
               state <= CTRL_RECOVER;
               flush <= 1'b0;
            end else begin
               fcnt <= fcnt - 3'd1;
            end
            CTRL_RECOVER: state <= CTRL_RUN;
            default: state <= CTRL_RUN;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) stall_cycles <= ZERO_WORD;
      else if (stall != STALL_NONE) stall_cycles <= stall_cycles + 32'd1;
   end
   stall_watchdog #(.MAX_STALL(MAX_STALL)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .active (stall != STALL_NONE),
      .clear  (stall == STALL_NONE),
      .timeout(stall_timeout)
   );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench; u0 has FLUSH_CYCLES=1/MAX_STALL=4, u1 has FLUSH_CYCLES=3
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id, stallreq_ex, stallreq_mem;
   logic [31:0] excepttype_i, cp0_epc_i;
   logic [5:0]  stall0, stall1;
   logic        flush0, flush1, to0, to1;
   logic [31:0] pc0, pc1, sc0, sc1;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.FLUSH_CYCLES(1), .MAX_STALL(4)) u0 (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .stallreq_mem(stallreq_mem), .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
      .stall(stall0), .flush(flush0), .new_pc(pc0), .stall_timeout(to0), .stall_cycles(sc0)
   );
   pipe_ctrl #(.FLUSH_CYCLES(3)) u1 (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .stallreq_mem(stallreq_mem), .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
      .stall(stall1), .flush(flush1), .new_pc(pc1), .stall_timeout(to1), .stall_cycles(sc1)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; excepttype_i = 0;
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      rst = 1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 1;
      excepttype_i = 0; cp0_epc_i = 0;
      repeat (2) cyc();
      checks++; if (stall0 !== 6'b000000) begin errors++; $display("FAIL rst_stall got=%b exp=000000", stall0); end
      rst = 0; stallreq_mem = 0;
      #1;
      checks++; if (stall0 !== 6'b000000) begin errors++; $display("FAIL reset_stall got=%b exp=000000", stall0); end
      checks++; if (flush0 !== 1'b0 || flush1 !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b/%b exp=0/0", flush0, flush1); end
      checks++; if (pc0 !== 32'h0 || pc1 !== 32'h0) begin errors++; $display("FAIL reset_new_pc got=%h/%h exp=0", pc0, pc1); end
      checks++; if (sc0 !== 32'h0 || sc1 !== 32'h0) begin errors++; $display("FAIL reset_stall_cycles got=%0d/%0d exp=0", sc0, sc1); end
      checks++; if (to0 !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", to0); end
   endtask

   task automatic test_priority();
      stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
      #1;
      checks++; if (stall0 !== 6'b011111) begin errors++; $display("FAIL prio_all got=%b exp=011111", stall0); end
      cyc();
      stallreq_ex = 0; stallreq_mem = 1'b0;
      #1;
      checks++; if (stall0 !== 6'b000111) begin errors++; $display("FAIL prio_id1 got=%b exp=000111", stall0); end
      cyc();
      checks++; if (stall0 !== 6'b000111) begin errors++; $display("FAIL prio_id2 got=%b exp=000111", stall0); end
      stallreq_ex = 1;
      #1;
      checks++; if (stall0 !== 6'b001111) begin errors++; $display("FAIL prio_ex got=%b exp=001111", stall0); end
      stallreq_ex = 0;
      cyc();
      stallreq_id = 0;
      #1;
      checks++; if (stall0 !== 6'b000000) begin errors++; $display("FAIL prio_none got=%b exp=000000", stall0); end
      checks++; if (sc0 !== 32'd3 || sc1 !== 32'd3) begin errors++; $display("FAIL prio_stall_cycles got=%0d/%0d exp=3", sc0, sc1); end
   endtask

   task automatic test_exception();
      excepttype_i = 32'h8; stallreq_ex = 1;
      #1;
      checks++; if (stall0 !== 6'b000000) begin errors++; $display("FAIL exc_stall_drop got=%b exp=000000", stall0); end
      cyc();
      excepttype_i = 0; stallreq_ex = 0;
      checks++; if (flush0 !== 1'b1) begin errors++; $display("FAIL exc_flush got=%b exp=1", flush0); end
      checks++; if (pc0 !== 32'h20) begin errors++; $display("FAIL exc_new_pc got=%h exp=00000020", pc0); end
      checks++; if (sc0 !== 32'd3) begin errors++; $display("FAIL exc_stall_cycles got=%0d exp=3", sc0); end
      cyc();
      checks++; if (flush0 !== 1'b0) begin errors++; $display("FAIL exc_flush_end got=%b exp=0", flush0); end
      excepttype_i = 32'h8;
      cyc();
      excepttype_i = 0;
      checks++; if (flush0 !== 1'b0) begin errors++; $display("FAIL recover_ignore got=%b exp=0", flush0); end
      cyc();
      checks++; if (flush0 !== 1'b0 || pc0 !== 32'h20) begin errors++; $display("FAIL recover_hold got=%b/%h exp=0/00000020", flush0, pc0); end
      idle(6);
   endtask

   task automatic test_eret();
      excepttype_i = 32'he; cp0_epc_i = 32'hBFC0_0100;
      cyc();
      excepttype_i = 0; cp0_epc_i = 0;
      checks++; if (flush0 !== 1'b1 || pc0 !== 32'hBFC0_0100) begin errors++; $display("FAIL eret got=%b/%h exp=1/bfc00100", flush0, pc0); end
      cyc();
      checks++; if (flush0 !== 1'b0 || pc0 !== 32'hBFC0_0100) begin errors++; $display("FAIL eret_end got=%b/%h exp=0/bfc00100", flush0, pc0); end
      idle(6);
   endtask

   task automatic test_watchdog();
      int pulses = 0;
      stallreq_mem = 1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (to0) pulses++;
         checks++; if (to0 !== (i == 4)) begin errors++; $display("FAIL wd_pulse edge=%0d got=%b exp=%b", i, to0, i == 4); end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL wd_single got=%0d exp=1", pulses); end
      stallreq_mem = 0;
      cyc();
      stallreq_mem = 1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         checks++; if (to0 !== (i == 4)) begin errors++; $display("FAIL wd_restart edge=%0d got=%b exp=%b", i, to0, i == 4); end
      end
      stallreq_mem = 0;
      cyc();
      checks++; if (to0 !== 1'b0) begin errors++; $display("FAIL wd_idle got=%b exp=0", to0); end
      checks++; if (sc0 !== 32'd17 || sc1 !== 32'd17) begin errors++; $display("FAIL wd_stall_cycles got=%0d/%0d exp=17", sc0, sc1); end
   endtask

   task automatic test_flush_reset();
      excepttype_i = 32'h8;
      cyc();
      excepttype_i = 0;
      checks++; if (flush1 !== 1'b1 || pc1 !== 32'h20) begin errors++; $display("FAIL fr_first got=%b/%h exp=1/00000020", flush1, pc1); end
      cyc();
      checks++; if (flush1 !== 1'b1) begin errors++; $display("FAIL fr_second got=%b exp=1", flush1); end
      rst = 1;
      cyc();
      rst = 0;
      checks++; if (flush1 !== 1'b0 || pc1 !== 32'h0) begin errors++; $display("FAIL fr_reset got=%b/%h exp=0/00000000", flush1, pc1); end
      checks++; if (sc1 !== 32'h0) begin errors++; $display("FAIL fr_stall_cycles got=%0d exp=0", sc1); end
      stallreq_id = 1;
      #1;
      checks++; if (stall1 !== 6'b000111) begin errors++; $display("FAIL fr_run got=%b exp=000111", stall1); end
      cyc();
      stallreq_id = 0;
      checks++; if (flush1 !== 1'b0 || sc1 !== 32'd1) begin errors++; $display("FAIL fr_after got=%b/%0d exp=0/1", flush1, sc1); end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_exception();
      test_eret();
      test_watchdog();
      test_flush_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
